// File: rtl/time_keeper.sv
// time_keeper: 24-hour HH:MM clock with button-driven time setting.
//   sysclk   : system clock, all state changes on its rising edge
//   rst_n    : asynchronous active-low reset
//   btn_mode : raw mode button (RUN -> SET_HOUR -> SET_MIN -> RUN)
//   btn_inc  : raw increment button (hours in SET_HOUR, minutes in SET_MIN)
//   h_tens/h_ones/m_tens/m_ones : registered BCD time digits
//   colon    : display colon enable (blinks in RUN, steady while setting)
//   mode     : current state, 00 RUN / 01 SET_HOUR / 10 SET_MIN
//   tick_1s  : one-cycle pulse per elapsed second in RUN
module time_keeper #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned DEBOUNCE = 200000
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] h_tens,
  output logic [3:0] h_ones,
  output logic [3:0] m_tens,
  output logic [3:0] m_ones,
  output logic       colon,
  output logic [1:0] mode,
  output logic       tick_1s
);

  localparam int unsigned PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PS_W-1:0] PS_MAX  = PS_W'(CLK_HZ - 1);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(CLK_HZ / 2);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_e;

  logic [1:0] w_btn_raw;
  logic [1:0] w_press;
  logic       w_mode_p;
  logic       w_inc_p;

  assign w_btn_raw = {btn_inc, btn_mode};
  assign w_mode_p  = w_press[0];
  assign w_inc_p   = w_press[1];

  // Per-button synchronizer, debouncer and rising-edge press detector
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic            r_sync1;
    logic            r_sync2;
    logic            r_filt;
    logic            r_filt_d;
    logic [DB_W-1:0] r_cnt;

    // r_cnt counts consecutive cycles the synchronized level differs from the filtered one
    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1  <= 1'b0;
        r_sync2  <= 1'b0;
        r_filt   <= 1'b0;
        r_filt_d <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_sync1  <= w_btn_raw[g];
        r_sync2  <= r_sync1;
        r_filt_d <= r_filt;
        if (r_sync2 == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_MAX) begin
          r_filt <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end
    end

    assign w_press[g] = r_filt & ~r_filt_d;
  end

  state_e r_state;
  state_e w_state_nxt;
  logic   w_run;
  logic   w_hour_inc;
  logic   w_min_inc;
  logic   w_set_exit;

  // FSM state register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: one step per mode press
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:      if (w_mode_p) w_state_nxt = ST_SET_HOUR;
      ST_SET_HOUR: if (w_mode_p) w_state_nxt = ST_SET_MIN;
      ST_SET_MIN:  if (w_mode_p) w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  // FSM control decode; increments act on the current state before the transition
  always_comb begin
    w_run      = 1'b0;
    w_hour_inc = 1'b0;
    w_min_inc  = 1'b0;
    w_set_exit = 1'b0;
    case (r_state)
      ST_RUN:      w_run      = 1'b1;
      ST_SET_HOUR: w_hour_inc = w_inc_p;
      ST_SET_MIN: begin
        w_min_inc  = w_inc_p;
        w_set_exit = w_mode_p;
      end
      default: ;
    endcase
  end

  logic [PS_W-1:0] r_presc;
  logic [PS_W-1:0] w_presc_nxt;
  logic            r_tick;
  logic            r_colon;

  // Prescaler only runs while staying in RUN; any other case parks it at 0
  always_comb begin
    w_presc_nxt = '0;
    if (w_run && (w_state_nxt == ST_RUN)) begin
      w_presc_nxt = (r_presc == PS_MAX) ? '0 : r_presc + PS_W'(1);
    end
  end

  // tick and colon are registered from the next prescaler value so they line up with it
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_colon <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_tick  <= w_run && (w_state_nxt == ST_RUN) && (w_presc_nxt == PS_MAX);
      r_colon <= (w_state_nxt != ST_RUN) || (w_presc_nxt < PS_HALF);
    end
  end

  logic [3:0] r_h_t, r_h_o, r_m_t, r_m_o, r_s_t, r_s_o;
  logic [3:0] w_h_t, w_h_o, w_m_t, w_m_o, w_s_t, w_s_o;
  logic       w_sec_carry;
  logic       w_min_step;
  logic       w_hour_step;

  // BCD time next-state: ripple carry from ticks, or direct edits while setting
  always_comb begin
    w_h_t = r_h_t;
    w_h_o = r_h_o;
    w_m_t = r_m_t;
    w_m_o = r_m_o;
    w_s_t = r_s_t;
    w_s_o = r_s_o;
    w_sec_carry = r_tick && (r_s_t == 4'd5) && (r_s_o == 4'd9);
    w_min_step  = w_sec_carry || w_min_inc;
    w_hour_step = (w_sec_carry && (r_m_t == 4'd5) && (r_m_o == 4'd9)) || w_hour_inc;

    if (r_tick) begin
      if (r_s_o == 4'd9) begin
        w_s_o = 4'd0;
        w_s_t = (r_s_t == 4'd5) ? 4'd0 : r_s_t + 4'd1;
      end else begin
        w_s_o = r_s_o + 4'd1;
      end
    end
    if (w_set_exit) begin
      w_s_t = 4'd0;
      w_s_o = 4'd0;
    end

    if (w_min_step) begin
      if (r_m_o == 4'd9) begin
        w_m_o = 4'd0;
        w_m_t = (r_m_t == 4'd5) ? 4'd0 : r_m_t + 4'd1;
      end else begin
        w_m_o = r_m_o + 4'd1;
      end
    end

    if (w_hour_step) begin
      if ((r_h_t == 4'd2) && (r_h_o == 4'd3)) begin
        w_h_t = 4'd0;
        w_h_o = 4'd0;
      end else if (r_h_o == 4'd9) begin
        w_h_o = 4'd0;
        w_h_t = r_h_t + 4'd1;
      end else begin
        w_h_o = r_h_o + 4'd1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_t <= 4'd0;
      r_h_o <= 4'd0;
      r_m_t <= 4'd0;
      r_m_o <= 4'd0;
      r_s_t <= 4'd0;
      r_s_o <= 4'd0;
    end else begin
      r_h_t <= w_h_t;
      r_h_o <= w_h_o;
      r_m_t <= w_m_t;
      r_m_o <= w_m_o;
      r_s_t <= w_s_t;
      r_s_o <= w_s_o;
    end
  end

  assign h_tens  = r_h_t;
  assign h_ones  = r_h_o;
  assign m_tens  = r_m_t;
  assign m_ones  = r_m_o;
  assign colon   = r_colon;
  assign mode    = r_state;
  assign tick_1s = r_tick;

endmodule

// File: tb/tb_time_keeper.sv
// Randomized bench for time_keeper against a minute-of-day reference model.
module tb_time_keeper;

  localparam int unsigned CLK_HZ   = 10;
  localparam int unsigned DEBOUNCE = 2;

  logic       sysclk   = 1'b0;
  logic       rst_n    = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc  = 1'b0;
  logic [3:0] h_tens, h_ones, m_tens, m_ones;
  logic       colon;
  logic [1:0] mode;
  logic       tick_1s;
  logic [15:0] disp;

  int n_checks = 0;
  int n_errors = 0;

  assign disp = {h_tens, h_ones, m_tens, m_ones};

  always #5 sysclk = ~sysclk;

  time_keeper #(
    .CLK_HZ   (CLK_HZ),
    .DEBOUNCE (DEBOUNCE)
  ) u_dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .h_tens   (h_tens),
    .h_ones   (h_ones),
    .m_tens   (m_tens),
    .m_ones   (m_ones),
    .colon    (colon),
    .mode     (mode),
    .tick_1s  (tick_1s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference display digits for a minute-of-day value
  function automatic logic [15:0] hhmm(input int mod);
    int hh;
    int mm;
    hh = mod / 60;
    mm = mod % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  task automatic do_reset();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  // Clean press: held long enough to pass the debouncer, then released long enough to re-arm
  task automatic press(input bit do_mode, input bit do_inc);
    @(negedge sysclk);
    btn_mode = do_mode;
    btn_inc  = do_inc;
    repeat (6) @(negedge sysclk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (6) @(negedge sysclk);
  endtask

  task automatic run_cycles(input int n, output int ticks, output int cols);
    ticks = 0;
    cols  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      ticks += int'(tick_1s);
      cols  += int'(colon);
    end
  endtask

  // Leave SET_MIN and stop on the first sample showing RUN (prescaler just cleared)
  task automatic enter_run(input string tag);
    @(negedge sysclk);
    btn_mode = 1'b1;
    for (int i = 0; i < 12 && mode != 2'b00; i++) @(negedge sysclk);
    check({tag, "_run_entry"}, 32'(mode), 32'd0);
    btn_mode = 1'b0;
  endtask

  // Set nh hour presses and nm minute presses from reset, return to RUN, run n_run cycles
  task automatic scenario(input int nh, input int nm, input int n_run, input string tag);
    int mod;
    int ticks;
    int cols;
    do_reset();
    press(1'b1, 1'b0);
    check({tag, "_mode_sh"}, 32'(mode), 32'd1);
    repeat (nh) press(1'b0, 1'b1);
    check({tag, "_hours"}, 32'(disp), 32'(hhmm((nh % 24) * 60)));
    press(1'b1, 1'b0);
    check({tag, "_mode_sm"}, 32'(mode), 32'd2);
    repeat (nm) press(1'b0, 1'b1);
    mod = (nh % 24) * 60 + (nm % 60);
    check({tag, "_set"}, 32'(disp), 32'(hhmm(mod)));
    enter_run(tag);
    run_cycles(n_run, ticks, cols);
    // Seconds restart at 00 on entry; whole minutes elapsed after n_run edges
    mod = (mod + (n_run / int'(CLK_HZ)) / 60) % 1440;
    check({tag, "_run_time"}, 32'(disp), 32'(hhmm(mod)));
    // Ticks land on RUN cycles CLK_HZ, 2*CLK_HZ, ...; the window spans cycles 2..n_run+1
    check({tag, "_ticks"}, 32'(ticks), 32'((n_run + 1) / int'(CLK_HZ)));
  endtask

  initial begin
    int ticks;
    int cols;
    int nh;
    int nm;
    int nr;

    // Reset asserted before any clock edge
    #1 rst_n = 1'b0;
    #3;
    check("rst_disp", 32'(disp), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_colon", 32'(colon), 32'd0);
    check("rst_tick", 32'(tick_1s), 32'd0);
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;

    // 600 cycles of RUN from reset
    run_cycles(600, ticks, cols);
    check("run600_time", 32'(disp), 32'(hhmm(1)));
    check("run600_ticks", 32'(ticks), 32'd60);
    check("run600_colon", 32'(cols), 32'd300);

    // Wrap of hour and minute editing, then 23:59 rollover through RUN
    scenario(24, 61, 50, "wrap");
    scenario(23, 59, 600, "carry");

    // Randomized settings and run lengths
    for (int k = 0; k < 4; k++) begin
      nh = int'($urandom_range(0, 30));
      nm = int'($urandom_range(0, 70));
      nr = int'($urandom_range(0, 1500));
      scenario(nh, nm, nr, $sformatf("rnd%0d", k));
    end

    // Single-cycle glitch is filtered; a long hold is exactly one transition
    do_reset();
    @(negedge sysclk);
    btn_mode = 1'b1;
    @(negedge sysclk);
    btn_mode = 1'b0;
    repeat (10) @(negedge sysclk);
    check("glitch_mode", 32'(mode), 32'd0);
    btn_mode = 1'b1;
    repeat (50) @(negedge sysclk);
    btn_mode = 1'b0;
    repeat (10) @(negedge sysclk);
    check("hold_mode", 32'(mode), 32'd1);

    // Increment presses ignored in RUN
    do_reset();
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("run_inc_disp", 32'(disp), 32'd0);
    check("run_inc_mode", 32'(mode), 32'd0);

    // Coincident mode+inc in SET_HOUR at 05
    do_reset();
    press(1'b1, 1'b0);
    repeat (5) press(1'b0, 1'b1);
    check("sim_pre", 32'(disp), 32'(hhmm(300)));
    check("set_colon", 32'(colon), 32'd1);
    press(1'b1, 1'b1);
    check("sim_disp", 32'(disp), 32'(hhmm(360)));
    check("sim_mode", 32'(mode), 32'd2);

    // Asynchronous reset in SET_MIN at 12:34
    do_reset();
    press(1'b1, 1'b0);
    repeat (12) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (34) press(1'b0, 1'b1);
    check("mid_set", 32'(disp), 32'(hhmm(12 * 60 + 34)));
    check("mid_mode", 32'(mode), 32'd2);
    @(posedge sysclk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_disp", 32'(disp), 32'd0);
    check("mid_rst_mode", 32'(mode), 32'd0);
    check("mid_rst_colon", 32'(colon), 32'd0);
    @(negedge sysclk);
    rst_n = 1'b1;
    run_cycles(25, ticks, cols);
    check("post_rst_ticks", 32'(ticks), 32'd2);
    check("post_rst_disp", 32'(disp), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
